// File: rtl/lut_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_pkg
// Description : Shared constants and FSM state type for the LUT config loader.
//               Optional parity frame enabled by macro LUT_CFG_PARITY_EN.
// Revision    : 1.0
// ============================================================================
package lut_cfg_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int CFG_BITS       = 2 ** ADDR_W_DEFAULT;

`ifdef LUT_CFG_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_BITS = CFG_BITS + PARITY_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lut_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_loader_if
// Description : Serial frame input and LUT write-port bundle of the loader.
// Revision    : 1.0
// ============================================================================
interface lut_cfg_loader_if #(
    parameter int ADDR_W = lut_cfg_pkg::ADDR_W_DEFAULT
);
    logic              i_frame_start;
    logic              i_shift_valid;
    logic              i_sdi;
    logic [ADDR_W-1:0] o_addr;
    logic              o_data;
    logic              o_config_enable;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_frame_start, i_shift_valid, i_sdi,
        input  o_addr, o_data, o_config_enable, o_busy, o_done, o_err
    );

    modport slave (
        input  i_frame_start, i_shift_valid, i_sdi,
        output o_addr, o_data, o_config_enable, o_busy, o_done, o_err
    );
endinterface
`default_nettype wire

// File: rtl/lut_cfg_shreg.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_shreg
// Description : MSB-first shift register with clear and parallel read port.
// Revision    : 1.0
// ============================================================================
module lut_cfg_shreg #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_shift_en,
    input  wire logic             i_sdi,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // A clear combined with a shift loads the new bit as the first of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= {{(WIDTH-1){1'b0}}, i_shift_en & i_sdi};
        end else if (i_shift_en) begin
            r_q <= {r_q[WIDTH-2:0], i_sdi};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_loader
// Description : Receives a serial LUT configuration frame and replays it as
//               one registered LUT write per address. Macro LUT_CFG_PARITY_EN
//               adds a trailing even-parity bit and frame rejection.
// Revision    : 1.0
// ============================================================================
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    lut_cfg_loader_if.slave bus
);

    localparam int C_DATA_BITS  = 2 ** ADDR_W;
    localparam int C_FRAME_BITS = C_DATA_BITS + PARITY_BITS;
    localparam int C_CNT_W      = $clog2(C_FRAME_BITS + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_BIT  = C_CNT_W'(C_FRAME_BITS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  C_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]  C_ADDR_ONE  = ADDR_W'(1);

    state_t                 r_state,   w_next_state;
    logic [C_CNT_W-1:0]     r_bit_cnt, w_next_cnt;
    logic [ADDR_W-1:0]      r_wr_addr, w_next_wr_addr;
    logic [C_DATA_BITS-1:0] w_shadow;
    logic                   w_clr, w_shift;
    logic                   w_cfg_en, w_data, w_done, w_busy;
    logic [ADDR_W-1:0]      w_addr;
    logic                   r_cfg_en, r_data, r_done, r_busy;
    logic [ADDR_W-1:0]      r_addr;
`ifdef LUT_CFG_PARITY_EN
    logic                   w_err, r_err;
`endif

    lut_cfg_shreg #(
        .WIDTH (C_DATA_BITS)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr & ena),
        .i_shift_en (w_shift & ena),
        .i_sdi      (bus.i_sdi),
        .o_q        (w_shadow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_wr_addr <= '0;
            r_cfg_en  <= 1'b0;
            r_addr    <= '0;
            r_data    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (ena) begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_cnt;
            r_wr_addr <= w_next_wr_addr;
            r_cfg_en  <= w_cfg_en;
            r_addr    <= w_addr;
            r_data    <= w_data;
            r_done    <= w_done;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_bit_cnt;
        w_next_wr_addr = r_wr_addr;
        w_clr          = 1'b0;
        w_shift        = 1'b0;
        w_cfg_en       = 1'b0;
        w_addr         = '0;
        w_data         = 1'b0;
        w_done         = 1'b0;
`ifdef LUT_CFG_PARITY_EN
        w_err          = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_SHIFT: begin
                if (bus.i_frame_start) begin
                    w_next_state = ST_SHIFT;
                    w_clr        = 1'b1;
                    w_shift      = bus.i_shift_valid;
                    w_next_cnt   = bus.i_shift_valid ? C_CNT_ONE : '0;
                end else if (r_state == ST_SHIFT && bus.i_shift_valid) begin
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_next_cnt = '0;
`ifdef LUT_CFG_PARITY_EN
                        // Trailing bit is parity, never shifted into the shadow.
                        if (bus.i_sdi != ^w_shadow) begin
                            w_err        = 1'b1;
                            w_next_state = ST_IDLE;
                        end else begin
                            w_next_state = ST_WRITE;
                        end
`else
                        w_shift      = 1'b1;
                        w_next_state = ST_WRITE;
`endif
                    end else begin
                        w_shift    = 1'b1;
                        w_next_cnt = r_bit_cnt + C_CNT_ONE;
                    end
                end
            end
            ST_WRITE: begin
                w_cfg_en = 1'b1;
                w_addr   = r_wr_addr;
                w_data   = w_shadow[r_wr_addr];
                if (r_wr_addr == C_LAST_ADDR) begin
                    w_next_state   = ST_DONE;
                    w_next_wr_addr = '0;
                end else begin
                    w_next_wr_addr = r_wr_addr + C_ADDR_ONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Busy stays high through the final registered write beat.
        w_busy = (w_next_state == ST_SHIFT) || (w_next_state == ST_WRITE) ||
                 (r_state == ST_WRITE);
    end

`ifdef LUT_CFG_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (ena) begin
            r_err <= w_err;
        end
    end
    assign bus.o_err = r_err;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_config_enable = r_cfg_en;
    assign bus.o_addr          = r_addr;
    assign bus.o_data          = r_data;
    assign bus.o_done          = r_done;
    assign bus.o_busy          = r_busy;

endmodule
`default_nettype wire
